// File: rtl/crossroad_sequencer.sv
// Two-lane crossroad light sequencer.
// Demand-driven green swaps with min/max green, yellow, all-red and car release.
module crossroad_sequencer #(
  parameter int TICK_DIV    = 100000000,
  parameter int GREEN_MIN_T = 5,
  parameter int GREEN_MAX_T = 20,
  parameter int YELLOW_T    = 2,
  parameter int PASS_T      = 1,
  parameter int CNT_W       = 4
) (
  input  logic             CLK100MHZ,
  input  logic             CPU_RESETN,
  input  logic             enable,
  input  logic [CNT_W-1:0] car_counter_a1,
  input  logic [CNT_W-1:0] car_counter_a2,
  input  logic [CNT_W-1:0] car_counter_b1,
  input  logic [CNT_W-1:0] car_counter_b2,
  output logic             crossroad_status_changed_out,
  output logic             signal_car_to_cross_out,
  output logic [2:0]       phase,
  output logic             lane_a_green,
  output logic             lane_b_green,
  output logic             yellow
);

  localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW  = $clog2(GREEN_MAX_T + 1);
  localparam int PSW = (PASS_T > 1) ? $clog2(PASS_T) : 1;

  localparam logic [PW-1:0]  PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0]  MIN_C     = TW'(GREEN_MIN_T);
  localparam logic [TW-1:0]  MAX_C     = TW'(GREEN_MAX_T);
  localparam logic [TW-1:0]  YEL_C     = TW'(YELLOW_T);
  localparam logic [PSW-1:0] PASS_LAST = PSW'(PASS_T - 1);

  typedef enum logic [2:0] {
    ALL_RED  = 3'd0,
    A_GREEN  = 3'd1,
    A_YELLOW = 3'd2,
    B_GREEN  = 3'd3,
    B_YELLOW = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  pre_q, pre_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [TW-1:0]  timer_inc;
  logic [PSW-1:0] pass_q, pass_d;
  logic           car_q, car_d;
  logic           stat_q, stat_d;
  logic           a_q, b_q, y_q;
  logic           tick, pass_fire;
  logic           go_a, go_b, yel_done;
  logic [CNT_W:0] qa, qb;

  assign qa = {1'b0, car_counter_a1} + {1'b0, car_counter_a2};
  assign qb = {1'b0, car_counter_b1} + {1'b0, car_counter_b2};

  always_comb begin
    tick      = enable && (pre_q == PRE_LAST);
    pre_d     = pre_q;
    if (enable) pre_d = tick ? '0 : pre_q + 1'b1;
    timer_inc = (timer_q >= MAX_C) ? timer_q : timer_q + 1'b1;
    pass_fire = (pass_q == PASS_LAST);
    // timer_inc is the tick count this tick lands on
    go_a      = (timer_inc >= MIN_C) && (qb != '0)
             && ((qa == '0) || (timer_inc >= MAX_C));
    go_b      = (timer_inc >= MIN_C) && (qa != '0)
             && ((qb == '0) || (timer_inc >= MAX_C));
    yel_done  = (timer_inc >= YEL_C);
  end

  always_comb begin
    state_d = state_q;
    car_d   = 1'b0;
    stat_d  = 1'b0;
    case (state_q)
      ALL_RED: begin
        if (tick && yel_done) state_d = A_GREEN;
      end
      A_GREEN: begin
        if (tick) begin
          if (go_a) state_d = A_YELLOW;
          else if ((qa != '0) && pass_fire) car_d = 1'b1;
        end
      end
      A_YELLOW: begin
        if (tick && yel_done) begin
          state_d = B_GREEN;
          stat_d  = 1'b1;
        end
      end
      B_GREEN: begin
        if (tick) begin
          if (go_b) state_d = B_YELLOW;
          else if ((qb != '0) && pass_fire) car_d = 1'b1;
        end
      end
      B_YELLOW: begin
        if (tick && yel_done) begin
          state_d = A_GREEN;
          stat_d  = 1'b1;
        end
      end
      default: state_d = ALL_RED;
    endcase
  end

  always_comb begin
    timer_d = timer_q;
    pass_d  = pass_q;
    if (state_d != state_q) begin
      timer_d = '0;
      pass_d  = '0;
    end else if (tick) begin
      timer_d = timer_inc;
      pass_d  = pass_fire ? '0 : pass_q + 1'b1;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q <= ALL_RED;
      pre_q   <= '0;
      timer_q <= '0;
      pass_q  <= '0;
      car_q   <= 1'b0;
      stat_q  <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      timer_q <= timer_d;
      pass_q  <= pass_d;
      // a pending pulse waits out a pause instead of being lost
      if (enable) begin
        car_q  <= car_d;
        stat_q <= stat_d;
      end
      a_q <= (state_d == A_GREEN);
      b_q <= (state_d == B_GREEN);
      y_q <= (state_d == A_YELLOW) || (state_d == B_YELLOW);
    end
  end

  assign phase                        = state_q;
  assign lane_a_green                 = a_q;
  assign lane_b_green                 = b_q;
  assign yellow                       = y_q;
  assign signal_car_to_cross_out      = car_q & enable;
  assign crossroad_status_changed_out = stat_q & enable;

endmodule

// File: tb/tb_crossroad_sequencer.sv
// Directed bench for crossroad_sequencer.
// Small tick/timer values; expectations counted in clock edges from reset release.
module tb_crossroad_sequencer;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] a1, a2, b1, b2;
  logic       stat, car;
  logic [2:0] phase;
  logic       la, lb, y;

  int n_chk;
  int n_pass;
  int viol;

  crossroad_sequencer #(
    .TICK_DIV    (4),
    .GREEN_MIN_T (3),
    .GREEN_MAX_T (6),
    .YELLOW_T    (2),
    .PASS_T      (1),
    .CNT_W       (4)
  ) dut (
    .CLK100MHZ                    (clk),
    .CPU_RESETN                   (rst_n),
    .enable                       (en),
    .car_counter_a1               (a1),
    .car_counter_a2               (a2),
    .car_counter_b1               (b1),
    .car_counter_b2               (b2),
    .crossroad_status_changed_out (stat),
    .signal_car_to_cross_out      (car),
    .phase                        (phase),
    .lane_a_green                 (la),
    .lane_b_green                 (lb),
    .yellow                       (y)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic run(input int n, output int cars, output int stats);
    cars  = 0;
    stats = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (car) cars++;
      if (stat) stats++;
      if (car && stat) viol++;
    end
  endtask

  task automatic do_reset(input logic [3:0] va1, input logic [3:0] va2,
                          input logic [3:0] vb1, input logic [3:0] vb2);
    int c, s;
    rst_n = 1'b0;
    en    = 1'b1;
    a1 = va1; a2 = va2; b1 = vb1; b2 = vb2;
    run(3, c, s);
    rst_n = 1'b1;
  endtask

  logic [3:0] va1_t [2];
  logic [3:0] va2_t [2];
  logic [3:0] vb1_t [2];
  logic [3:0] vb2_t [2];

  initial begin
    int c, s, c2, s2;
    n_chk = 0;
    n_pass = 0;
    viol = 0;
    va1_t[0] = 4'd2;  va2_t[0] = 4'd3; vb1_t[0] = 4'd4; vb2_t[0] = 4'd1;
    va1_t[1] = 4'd15; va2_t[1] = 4'd1; vb1_t[1] = 4'd1; vb2_t[1] = 4'd0;

    rst_n = 1'b0;
    en = 1'b1;
    a1 = '0; a2 = '0; b1 = '0; b2 = '0;
    run(3, c, s);
    chk("rst_phase", 32'(phase), 0);
    chk("rst_lights", {29'd0, la, lb, y}, 0);
    chk("rst_pulses", {30'd0, car, stat}, 0);

    rst_n = 1'b1;
    run(7, c, s);
    chk("allred_hold", 32'(phase), 0);
    run(1, c2, s2);
    chk("agreen_entry", 32'(phase), 1);
    chk("agreen_light", {29'd0, la, lb, y}, 3'b100);
    chk("no_stat_from_red", 32'(s + s2), 0);

    a1 = 4'd2;
    run(3, c, s);
    chk("car_before_tick", 32'(c), 0);
    run(1, c, s);
    chk("car_first_tick", 32'(car), 1);
    run(40, c, s);
    chk("car_every_4", 32'(c), 10);
    chk("a_hold_no_b", 32'(phase), 1);

    do_reset(4'd0, 4'd0, 4'd3, 4'd0);
    run(8, c, s);
    chk("q0_agreen", 32'(phase), 1);
    run(11, c, s);
    chk("q0_min_hold", 32'(phase), 1);
    chk("q0_no_cars", 32'(c), 0);
    run(1, c, s);
    chk("q0_ayel", 32'(phase), 2);
    chk("q0_ayel_light", {29'd0, la, lb, y}, 3'b001);
    chk("q0_no_car_sw", 32'(car), 0);
    run(7, c, s);
    chk("yel_hold", 32'(phase), 2);
    chk("yel_no_pulse", 32'(c + s), 0);
    run(1, c, s);
    chk("bgreen", 32'(phase), 3);
    chk("stat_pulse", 32'(stat), 1);
    chk("bgreen_light", {29'd0, la, lb, y}, 3'b010);
    run(1, c, s);
    chk("stat_one_clk", 32'(stat), 0);
    run(20, c, s);
    chk("b_cars", 32'(c), 5);
    chk("b_hold", 32'(phase), 3);
    chk("b_no_stat", 32'(s), 0);

    for (int v = 0; v < 2; v++) begin
      do_reset(va1_t[v], va2_t[v], vb1_t[v], vb2_t[v]);
      run(8, c, s);
      chk("max_agreen", 32'(phase), 1);
      run(23, c, s);
      chk("max_cars", 32'(c), 5);
      chk("max_hold", 32'(phase), 1);
      run(1, c, s);
      chk("max_switch", 32'(phase), 2);
      chk("max_no_car", 32'(car), 0);
    end

    run(1, c, s);
    chk("pre_rst_yel", 32'(phase), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_phase", 32'(phase), 0);
    chk("async_lights", {29'd0, la, lb, y}, 0);
    chk("async_pulses", {30'd0, car, stat}, 0);

    do_reset(4'd1, 4'd0, 4'd3, 4'd0);
    run(8, c, s);
    chk("en_agreen", 32'(phase), 1);
    run(4, c, s);
    chk("en_car_tick1", 32'(car), 1);
    en = 1'b0;
    #1;
    chk("en_gate_car", 32'(car), 0);
    en = 1'b1;
    run(2, c, s);
    en = 1'b0;
    run(20, c, s);
    chk("en_off_pulses", 32'(c + s), 0);
    chk("en_off_hold", 32'(phase), 1);
    en = 1'b1;
    run(17, c, s);
    chk("en_resume_cars", 32'(c), 4);
    chk("en_resume_hold", 32'(phase), 1);
    run(1, c, s);
    chk("en_late_switch", 32'(phase), 2);

    chk("pulse_excl", 32'(viol), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/crossroad_sequencer.md
CROSSROAD_SEQUENCER -- requirements
Module: crossroad_sequencer

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset; all state changes occur on the rising clock edge except reset.
REQ-002 Parameter TICK_DIV, default 100000000, SHALL set the clocks per timing tick (1 s at 100 MHz).
REQ-003 Parameter GREEN_MIN_T, default 5, SHALL set the minimum green time in ticks.
REQ-004 Parameter GREEN_MAX_T, default 20, SHALL set the green time in ticks after which a waiting opposite lane forces a switch.
REQ-005 Parameter YELLOW_T, default 2, SHALL set the yellow and all-red times in ticks.
REQ-006 Parameter PASS_T, default 1, SHALL set the ticks between successive car-cross pulses.
REQ-007 Parameter CNT_W, default 4, SHALL set the car counter width.
REQ-008 CLK100MHZ  in  1  system clock.
REQ-009 CPU_RESETN  in  1  asynchronous active-low reset.
REQ-010 enable  in  1  run enable; low freezes the prescaler, timers and state.
REQ-011 car_counter_a1, car_counter_a2, car_counter_b1, car_counter_b2  in  CNT_W each  queued cars per lane.
REQ-012 crossroad_status_changed_out  out  1  one-cycle pulse per lane swap.
REQ-013 signal_car_to_cross_out  out  1  one-cycle pulse releasing one car from the green lane.
REQ-014 phase  out  3  current state encoding.
REQ-015 lane_a_green, lane_b_green, yellow  out  1 each  registered light indications.

Function
REQ-016 States and phase encoding SHALL be ALL_RED=0, A_GREEN=1, A_YELLOW=2, B_GREEN=3, B_YELLOW=4; codes 5-7 SHALL go to ALL_RED on the next clock.
REQ-017 The prescaler SHALL count 0..TICK_DIV-1 while enable is high, with a one-cycle internal tick on wrap.
REQ-018 Phase timer SHALL clear on state entry, increment on each tick, and saturate at GREEN_MAX_T.
REQ-019 Queue sums qa=a1+a2 and qb=b1+b2 SHALL be computed at CNT_W+1 bits without overflow.
REQ-020 ALL_RED SHALL move to A_GREEN on the tick where the timer reaches YELLOW_T, with no status pulse.
REQ-021 X_GREEN SHALL move to X_YELLOW on a tick where timer>=GREEN_MIN_T and the opposite sum is nonzero, and either the own sum is zero or timer>=GREEN_MAX_T.
REQ-022 When the opposite sum is zero, X_GREEN SHALL hold regardless of timer value.
REQ-023 X_YELLOW SHALL move to the opposite GREEN on the tick where the timer reaches YELLOW_T, and crossroad_status_changed_out SHALL pulse high for exactly the first clock of the new GREEN.
REQ-024 In X_GREEN with own sum nonzero, signal_car_to_cross_out SHALL pulse for one clock on every PASS_T-th tick since green entry.
REQ-025 On a tick that causes GREEN to YELLOW, no car pulse SHALL be issued.
REQ-026 No car pulse SHALL be issued in YELLOW or ALL_RED.
REQ-027 Light outputs SHALL be registered: lane_a_green=1 only in A_GREEN, lane_b_green=1 only in B_GREEN, yellow=1 only in A_YELLOW or B_YELLOW, all low in ALL_RED.
REQ-028 With enable low, both pulse outputs SHALL be 0 and all counters and state SHALL hold; counting SHALL resume from the held values.
REQ-029 Both pulse outputs SHALL never be high in the same cycle.

Reset
REQ-030 Asserting CPU_RESETN low SHALL immediately force phase=0, all light outputs 0, both pulses 0, and prescaler and timers 0, from any state.
REQ-031 After CPU_RESETN deasserts, the first tick SHALL occur TICK_DIV enabled clocks later.

Verification
Bench parameters: TICK_DIV=4, GREEN_MIN_T=3, GREEN_MAX_T=6, YELLOW_T=2, PASS_T=1.
REQ-032 Release reset with enable=1 and all counters 0 -> phase=0 for 8 clocks, then phase=1 and lane_a_green=1, no status pulse.
REQ-033 In A_GREEN with a1=2 and b counters 0 -> one car pulse every 4 clocks; phase stays 1 indefinitely.
REQ-034 At A_GREEN entry with qa=0 and b1=3 -> phase=2 at tick 3 and phase=3 two ticks later; the status pulse is high for exactly 1 clock at B_GREEN entry.
REQ-035 With qa=5 and qb=5 held constant in A_GREEN -> car pulses on ticks 1-5 and none on tick 6; phase=2 at tick 6.
REQ-036 Assert reset during A_YELLOW -> outputs reach reset values in the same cycle, with no clock edge required.
REQ-037 Drop enable for 20 clocks mid-green -> no pulses, phase held; on re-enable the switch occurs exactly 20 clocks later than the enable-always baseline.
